// File: rtl/tone_sequencer.sv
// tone_sequencer
// Steps through a small table of (prescaler, duration) entries and drives the
// square-wave generator's enable and prescaler inputs. Every note starts with
// one LOAD cycle where the enable is low, so the generator's phase counter
// restarts cleanly between notes.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   wr_en          table write strobe (one entry per cycle, any state)
//   wr_addr        table entry to write
//   wr_presc       entry prescaler, 16'hFFFF marks a rest
//   wr_dur         entry length in ticks (0 behaves as 1)
//   len            entries to play, sampled on accepted start, clamped to DEPTH
//   loop           repeat until stop, sampled on accepted start
//   start          begin playback (level, only acted on in IDLE)
//   stop           abort playback, wins over start and note-end transitions
//   wave_ena       generator enable
//   wave_prescaler generator prescaler
//   busy           high in LOAD and PLAY
//   done           one-cycle pulse when a non-looping sequence completes
//   cur_idx        entry currently loaded or playing
//   dbg_state      current FSM state (IDLE=0, LOAD=1, PLAY=2, DONE=3)
//
// Handshake: there is no ready/valid pair. start is a level request accepted
// only when the FSM is IDLE, len is non-zero and stop is low; wr_en is a
// fire-and-forget strobe accepted every cycle.
module tone_sequencer #(
   parameter  int DEPTH    = 8,
   parameter  int TICK_DIV = 1000,
   localparam int AW       = $clog2(DEPTH),
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_presc,
   input  logic [15:0]   wr_dur,
   input  logic [AW:0]   len,
   input  logic          loop,
   input  logic          start,
   input  logic          stop,
   output logic          wave_ena,
   output logic [15:0]   wave_prescaler,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_idx,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [15:0]   REST      = 16'hFFFF;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW:0]   LEN_MAX   = (AW + 1)'(DEPTH);

   logic [15:0] presc_mem [DEPTH];
   logic [15:0] dur_mem   [DEPTH];

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW:0]   len_q, len_d;
   logic          loop_q, loop_d;
   logic [15:0]   presc_q, presc_d;
   logic [15:0]   dur_q, dur_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          ena_q, busy_q, done_q;

   logic          last_entry;

   // Table. A write on the same edge as a LOAD read is not seen by that read
   // because the read samples the registered contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            presc_mem[i] <= '0;
            dur_mem[i]   <= '0;
         end
      end else if (wr_en) begin
         presc_mem[wr_addr] <= wr_presc;
         dur_mem[wr_addr]   <= wr_dur;
      end
   end

   assign last_entry = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      loop_d  = loop_q;
      presc_d = presc_q;
      dur_d   = dur_q;
      tick_d  = tick_q;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (len != '0)) begin
                  len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                  loop_d  = loop;
                  idx_d   = '0;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               presc_d = presc_mem[idx_q];
               dur_d   = (dur_mem[idx_q] == 16'd0) ? 16'd1 : dur_mem[idx_q];
               tick_d  = '0;
               state_d = S_PLAY;
            end
            S_PLAY: begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (dur_q == 16'd1) begin
                     if (!last_entry) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                     end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     dur_d = dur_q - 16'd1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Outputs are registered from the next-state values so they line up with
   // the state they describe without any input-to-output combinational path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         presc_q <= '0;
         dur_q   <= '0;
         tick_q  <= '0;
         ena_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         presc_q <= presc_d;
         dur_q   <= dur_d;
         tick_q  <= tick_d;
         ena_q   <= (state_d == S_PLAY) && (presc_d != REST);
         busy_q  <= (state_d == S_LOAD) || (state_d == S_PLAY);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign wave_ena       = ena_q;
   assign wave_prescaler = presc_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cur_idx        = idx_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with DEPTH=8, TICK_DIV=4. Expected per-cycle
// behaviour is derived from a shadow copy of the table and the timeline rules
// (one LOAD cycle, max(dur,1)*4 play cycles per note, a done cycle).
module tb_tone_sequencer;

   localparam int DEPTH = 8;
   localparam int TDIV  = 4;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_presc;
   logic [15:0] wr_dur;
   logic [3:0]  len;
   logic        loop;
   logic        start;
   logic        stop;
   logic        wave_ena;
   logic [15:0] wave_prescaler;
   logic        busy;
   logic        done;
   logic [2:0]  cur_idx;
   logic [1:0]  dbg_state;

   tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TDIV)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_presc       (wr_presc),
      .wr_dur         (wr_dur),
      .len            (len),
      .loop           (loop),
      .start          (start),
      .stop           (stop),
      .wave_ena       (wave_ena),
      .wave_prescaler (wave_prescaler),
      .busy           (busy),
      .done           (done),
      .cur_idx        (cur_idx),
      .dbg_state      (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   int          total = 0;
   int          bad   = 0;
   logic [21:0] exp_q[$];
   logic [15:0] m_presc [DEPTH];
   logic [15:0] m_dur   [DEPTH];
   logic [15:0] last_presc = 16'd0;
   logic [2:0]  last_idx   = 3'd0;

   // mid-run write hooks: cycle index, address, prescaler, duration
   int          hk_cyc[$];
   logic [2:0]  hk_addr[$];
   logic [15:0] hk_presc[$];
   logic [15:0] hk_dur[$];

   typedef struct {
      logic [15:0] presc;
      logic [15:0] dur;
      int          exp_busy;
      int          exp_ena;
   } vec_t;

   function automatic logic [21:0] mk(input logic e, input logic b, input logic d,
                                      input logic [2:0] i, input logic [15:0] p);
      return {e, b, d, i, p};
   endfunction

   function automatic logic [21:0] obs();
      return {wave_ena, busy, done, cur_idx, wave_prescaler};
   endfunction

   task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] p, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_presc = p; wr_dur = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      m_presc[a] = p;
      m_dur[a]   = d;
   endtask

   // Start a non-looping run of len_in entries and compare every cycle
   // against the timeline built from the shadow table.
   task automatic play_check(input string nm, input int len_in);
      int          n;
      int          cyc;
      int          d;
      logic [15:0] prev;
      logic [15:0] p;
      logic [21:0] e;
      n = (len_in > DEPTH) ? DEPTH : len_in;
      prev = last_presc;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'(i), prev));
         d = (m_dur[i] == 16'd0) ? 1 : int'(m_dur[i]);
         p = m_presc[i];
         for (int c = 0; c < d * TDIV; c++)
            exp_q.push_back(mk(p != 16'hFFFF, 1'b1, 1'b0, 3'(i), p));
         prev = p;
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 3'(n - 1), prev));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'(n - 1), prev));
      len = 4'(len_in); loop = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk(nm, cyc, 32'(obs()), 32'(e));
         wr_en = 1'b0;
         if (hk_cyc.size() > 0 && hk_cyc[0] == cyc) begin
            void'(hk_cyc.pop_front());
            wr_en    = 1'b1;
            wr_addr  = hk_addr.pop_front();
            wr_presc = hk_presc.pop_front();
            wr_dur   = hk_dur.pop_front();
            m_presc[wr_addr] = wr_presc;
            m_dur[wr_addr]   = wr_dur;
         end
         cyc++;
      end
      wr_en = 1'b0;
      last_presc = prev;
      last_idx   = 3'(n - 1);
      @(posedge clk); #1;
   endtask

   task automatic idle_check(input string nm, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         chk(nm, c, 32'(obs()), 32'(mk(1'b0, 1'b0, 1'b0, last_idx, last_presc)));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t        vecs[6];
      int          busy_n, ena_n, done_n;
      int          pos, ix;
      logic        ld;
      logic [15:0] pe;
      logic [21:0] ev;

      vecs[0] = '{presc: 16'd3,     dur: 16'd2, exp_busy: 9,  exp_ena: 8};
      vecs[1] = '{presc: 16'hFFFF,  dur: 16'd0, exp_busy: 5,  exp_ena: 0};
      vecs[2] = '{presc: 16'd5,     dur: 16'd0, exp_busy: 5,  exp_ena: 4};
      vecs[3] = '{presc: 16'd0,     dur: 16'd3, exp_busy: 13, exp_ena: 12};
      vecs[4] = '{presc: 16'hFFFE,  dur: 16'd1, exp_busy: 5,  exp_ena: 4};
      vecs[5] = '{presc: 16'h1234,  dur: 16'd4, exp_busy: 17, exp_ena: 16};

      for (int i = 0; i < DEPTH; i++) begin
         m_presc[i] = 16'd0;
         m_dur[i]   = 16'd0;
      end

      // reset
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_presc = '0; wr_dur = '0;
      len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 0, 32'(obs()), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idle_check("post_reset_idle", 2);

      // basic two-note sequence
      wr(3'd0, 16'd3, 16'd2);
      wr(3'd1, 16'd7, 16'd1);
      play_check("two_notes", 2);

      // single-note table
      foreach (vecs[v]) begin
         wr(3'd0, vecs[v].presc, vecs[v].dur);
         len = 4'd1; loop = 1'b0; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         busy_n = 0; ena_n = 0; done_n = 0;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            busy_n += int'(busy);
            ena_n  += int'(wave_ena);
            done_n += int'(done);
         end
         chk("vec_busy_cycles", v, 32'(busy_n), 32'(vecs[v].exp_busy));
         chk("vec_ena_cycles", v, 32'(ena_n), 32'(vecs[v].exp_ena));
         chk("vec_done_pulses", v, 32'(done_n), 32'(1));
         chk("vec_presc_hold", v, 32'(wave_prescaler), 32'(vecs[v].presc));
         last_presc = vecs[v].presc;
         last_idx   = 3'd0;
         @(posedge clk); #1;
      end

      // looping run for three passes, then stop mid-note
      wr(3'd0, 16'd100, 16'd1);
      wr(3'd1, 16'd200, 16'd1);
      len = 4'd2; loop = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         pos = c % 10;
         ix  = (pos < 5) ? 0 : 1;
         ld  = (pos % 5) == 0;
         if (ld)
            pe = (c == 0) ? last_presc : ((ix == 0) ? 16'd200 : 16'd100);
         else
            pe = (ix == 0) ? 16'd100 : 16'd200;
         chk("loop_cycle", c, 32'(obs()), 32'(mk(!ld, 1'b1, 1'b0, 3'(ix), pe)));
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      loop = 1'b0;
      last_presc = 16'd100;
      last_idx   = 3'd0;
      chk("stop_mid_note", 0, 32'(obs()), 32'(mk(1'b0, 1'b0, 1'b0, 3'd0, 16'd100)));
      @(posedge clk); #1;
      idle_check("after_stop_no_done", 6);

      // start together with stop, and start with len=0
      len = 4'd2; start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      idle_check("start_with_stop", 3);
      len = 4'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      idle_check("start_len0", 3);

      // len above DEPTH clamps
      for (int i = 0; i < DEPTH; i++)
         wr(3'(i), 16'(16'h40 + i), 16'(i % 2));
      play_check("len15_clamp", 15);

      // writes to the playing entry and a later entry
      wr(3'd0, 16'd10, 16'd1);
      wr(3'd1, 16'd11, 16'd2);
      wr(3'd2, 16'd12, 16'd1);
      m_presc[2] = 16'd22;
      hk_cyc.push_back(8); hk_addr.push_back(3'd1);
      hk_presc.push_back(16'd20); hk_dur.push_back(16'd1);
      hk_cyc.push_back(9); hk_addr.push_back(3'd2);
      hk_presc.push_back(16'd22); hk_dur.push_back(16'd1);
      play_check("write_during_play", 3);

      // write landing on the edge that LOADs the same entry
      hk_cyc.push_back(5); hk_addr.push_back(3'd1);
      hk_presc.push_back(16'd33); hk_dur.push_back(16'd1);
      play_check("write_at_load", 2);

      // reset mid-play clears outputs and the table
      wr(3'd0, 16'd55, 16'd3);
      len = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_mid_play", 0, 32'(obs()), 32'(0));
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH; i++) begin
         m_presc[i] = 16'd0;
         m_dur[i]   = 16'd0;
      end
      last_presc = 16'd0;
      last_idx   = 3'd0;
      play_check("after_reset_cleared", 1);

      // randomized tables and lengths
      for (int r = 0; r < 15; r++) begin
         for (int k = 0; k < 4; k++)
            wr(3'($urandom_range(0, 7)),
               ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom),
               16'($urandom_range(0, 3)));
         play_check("random_run", $urandom_range(1, 15));
      end

      ev = obs();
      chk("final_idle_busy", 0, 32'(ev[20]), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop if the sequence above ever stalls
   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
